// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write port.
// After reset a sequential engine zeroes every entry while busy is raised.
module regfile_2r1w #(
  parameter int N        = 5,
  parameter int M        = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] wadr,
  input  logic [M-1:0] din,
  input  logic [N-1:0] radr1,
  output logic [M-1:0] dout1,
  input  logic [N-1:0] radr2,
  output logic [M-1:0] dout2,
  output logic         busy
);
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << N;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {CLEAR, RUN} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   clr_cnt_q, clr_cnt_d;
  logic [M-1:0]   mem_q [DEPTH];

  logic           wr_en;
  logic [N-1:0]   wr_adr;
  logic [M-1:0]   wr_dat;

  logic [NUM_RD-1:0][N-1:0] radr_v;
  logic [NUM_RD-1:0][M-1:0] rdat_v;

  assign busy = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      if (&clr_cnt_q) state_d   = RUN;
      else            clr_cnt_d = clr_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The clear engine owns the write port for the whole CLEAR window.
  always_comb begin
    wr_en  = 1'b0;
    wr_adr = wadr;
    wr_dat = din;
    if (!rst) begin
      if (state_q == CLEAR) begin
        wr_en  = 1'b1;
        wr_adr = clr_cnt_q;
        wr_dat = '0;
      end else if (we && !(ZERO_REG != 0 && wadr == '0)) begin
        wr_en  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_adr] <= wr_dat;
  end

  assign radr_v = {radr2, radr1};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    always_comb begin
      rdat_v[g] = mem_q[radr_v[g]];
      if (BYPASS != 0 && we && wadr == radr_v[g]) rdat_v[g] = din;
      if (ZERO_REG != 0 && radr_v[g] == '0)       rdat_v[g] = '0;
      if (busy)                                   rdat_v[g] = '0;
    end
  end

  assign dout1 = rdat_v[0];
  assign dout2 = rdat_v[1];
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a default instance (zero reg + bypass) and a plain
// instance (no zero reg, no bypass) share stimulus and are checked against an array model.
module tb_regfile_2r1w;
  localparam int N = 5;
  localparam int M = 32;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         rst, we;
  logic [N-1:0] wadr, radr1, radr2;
  logic [M-1:0] din;
  logic [M-1:0] a_dout1, a_dout2, b_dout1, b_dout2;
  logic         a_busy, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [M-1:0] mem_a [DEPTH];
  logic [M-1:0] mem_b [DEPTH];
  bit           m_busy = 1'b1;
  int           m_left = DEPTH;

  always #5 clk = ~clk;

  regfile_2r1w #(.N(N), .M(M), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .wadr(wadr), .din(din),
    .radr1(radr1), .dout1(a_dout1), .radr2(radr2), .dout2(a_dout2), .busy(a_busy));

  regfile_2r1w #(.N(N), .M(M), .ZERO_REG(0), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .wadr(wadr), .din(din),
    .radr1(radr1), .dout1(b_dout1), .radr2(radr2), .dout2(b_dout2), .busy(b_busy));

  // Reference: after reset falls, DEPTH edges of busy, then the whole array reads zero.
  task automatic model_step();
    if (rst) begin
      m_busy = 1'b1;
      m_left = DEPTH;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_a[i] = '0;
          mem_b[i] = '0;
        end
        m_busy = 1'b0;
      end
    end else if (we) begin
      mem_b[wadr] = din;
      if (wadr != 0) mem_a[wadr] = din;
    end
  endtask

  function automatic logic [M-1:0] exp_rd(input bit zr, input bit bp, input logic [N-1:0] ra);
    if (m_busy) return '0;
    if (zr && ra == 0) return '0;
    if (bp && we && wadr == ra) return din;
    return zr ? mem_a[ra] : mem_b[ra];
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wadr = '0; din = '0; radr1 = '0; radr2 = '0;
    tick(); tick();
    n_checks++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 1", a_busy, b_busy);
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      radr1 = N'($urandom_range(0, DEPTH-1)); radr2 = N'(i);
      #1;
      n_checks++;
      if (a_busy !== 1'b1 || b_busy !== 1'b1 || a_dout1 !== '0 || b_dout2 !== '0) begin
        n_fail++; $display("FAIL clear_window edge %0d: busy %b/%b d %h/%h want 1/1 0/0",
                           i, a_busy, b_busy, a_dout1, b_dout2);
      end
      tick();
    end
    n_checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_done: busy %b/%b want 0", a_busy, b_busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      radr1 = N'(i); radr2 = N'(DEPTH-1-i);
      #1;
      n_checks++;
      if (a_dout1 !== '0 || a_dout2 !== '0 || b_dout1 !== '0 || b_dout2 !== '0) begin
        n_fail++; $display("FAIL cleared_entry %0d: got %h %h %h %h want 0",
                           i, a_dout1, a_dout2, b_dout1, b_dout2);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; wadr = 5; din = 32'hDEADBEEF;
    tick();
    we = 1'b0; radr1 = 5; radr2 = 5;
    #1;
    n_checks++;
    if (a_dout1 !== 32'hDEADBEEF || a_dout2 !== 32'hDEADBEEF ||
        b_dout1 !== 32'hDEADBEEF || b_dout2 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_read: got %h %h %h %h want deadbeef",
                         a_dout1, a_dout2, b_dout1, b_dout2);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wadr = 0; din = 32'h1234; radr1 = 0;
    #1;
    n_checks++;
    if (a_dout1 !== '0) begin
      n_fail++; $display("FAIL zero_reg_bypass: got %h want 0", a_dout1);
    end
    tick();
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (a_dout1 !== '0 || b_dout1 !== 32'h1234) begin
        n_fail++; $display("FAIL zero_reg: got %h/%h want 0/1234", a_dout1, b_dout1);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wadr = 7; din = 32'h1;
    tick();
    din = 32'hA5; radr2 = 7;
    #1;
    n_checks++;
    if (a_dout2 !== 32'hA5 || b_dout2 !== 32'h1) begin
      n_fail++; $display("FAIL bypass_pre: got %h/%h want a5/1", a_dout2, b_dout2);
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (a_dout2 !== 32'hA5 || b_dout2 !== 32'hA5) begin
      n_fail++; $display("FAIL bypass_post: got %h/%h want a5/a5", a_dout2, b_dout2);
    end
  endtask

  task automatic test_mid_clear();
    int edges;
    we = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    edges = 0;
    while (a_busy === 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges != DEPTH || m_busy) begin
      n_fail++; $display("FAIL mid_clear_len: got %0d edges want %0d", edges, DEPTH);
    end
  endtask

  task automatic test_busy_write();
    int edges;
    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0; we = 1'b1; wadr = 3; din = 32'hFF;
    edges = 0;
    while (m_busy && edges < 100) begin
      tick();
      edges++;
    end
    we = 1'b0; radr1 = 3;
    #1;
    n_checks++;
    if (a_busy !== 1'b0 || a_dout1 !== '0 || b_dout1 !== '0) begin
      n_fail++; $display("FAIL busy_write: busy %b got %h/%h want 0 0/0", a_busy, a_dout1, b_dout1);
    end
  endtask

  task automatic test_random();
    logic [M-1:0] e;
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      we    = $urandom_range(0, 1);
      wadr  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      radr1 = ($urandom_range(0, 3) == 0) ? wadr : N'($urandom);
      radr2 = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      din   = $urandom;
      #1;
      n_checks++;
      if (a_busy !== m_busy || b_busy !== m_busy) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %b/%b want %b", c, a_busy, b_busy, m_busy);
      end
      e = exp_rd(1'b1, 1'b1, radr1);
      n_checks++;
      if (a_dout1 !== e) begin
        n_fail++; $display("FAIL rnd_a_dout1 c%0d: got %h want %h", c, a_dout1, e);
      end
      e = exp_rd(1'b1, 1'b1, radr2);
      n_checks++;
      if (a_dout2 !== e) begin
        n_fail++; $display("FAIL rnd_a_dout2 c%0d: got %h want %h", c, a_dout2, e);
      end
      e = exp_rd(1'b0, 1'b0, radr1);
      n_checks++;
      if (b_dout1 !== e) begin
        n_fail++; $display("FAIL rnd_b_dout1 c%0d: got %h want %h", c, b_dout1, e);
      end
      e = exp_rd(1'b0, 1'b0, radr2);
      n_checks++;
      if (b_dout2 !== e) begin
        n_fail++; $display("FAIL rnd_b_dout2 c%0d: got %h want %h", c, b_dout2, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_mid_clear();
    test_busy_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
